// File: rtl/dac_spi_serializer_pkg.sv
// Shared definitions for the SPI DAC serializer.
// - dac_state_e        : FSM encoding (IDLE=0 .. LDAC=4, 3 bits)
// - DAC_CFG_DEFAULT    : upper four frame bits (A/B=0, BUF=0, GA_n=1, SHDN_n=1)
// - frame_bits()       : frame width for a given sample width
// - frame_cycles()     : accept-to-accept period in clk cycles
package dac_spi_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    LDAC  = 3'd4
  } dac_state_e;

  localparam int             DAC_CFG_BITS    = 4;
  localparam logic [3:0]     DAC_CFG_DEFAULT = 4'b0011;

  function automatic int frame_bits(input int data_bits);
    return data_bits + DAC_CFG_BITS;
  endfunction

  function automatic int frame_cycles(input int data_bits, input int sclk_half,
                                      input int ldac_cycles);
    return (2 * frame_bits(data_bits) + 2) * sclk_half + ldac_cycles;
  endfunction

endpackage

// File: rtl/dac_spi_serializer_tick_gen.sv
// Half-period tick generator for the SPI serializer.
// - clk, rst : system clock, async active-high reset
// - run      : count while high; counter clears while low
// - tick     : one-cycle pulse every SCLK_HALF cycles while run=1
module spi_tick_gen #(
  parameter int SCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int             CW   = $clog2(SCLK_HALF) + 1;
  localparam logic [CW-1:0]  TERM = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == TERM);

  // Phase changes only happen on tick, so the counter restarts at every
  // state boundary without an explicit reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (!run || tick) cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dac_spi_serializer.sv
// Serializes 12-bit samples into MCP4921-style 16-bit SPI frames {CFG, sample},
// MSB first (mode 0), then strobes LDAC_n so the DAC output updates.
// - clk, rst      : system clock, async active-high reset
// - sample_in     : unsigned sample, snapshotted on accept (valid & ready)
// - sample_valid  : sample_in valid
// - sample_ready  : registered, high only in IDLE
// - dac_cs_n      : chip select, active low
// - dac_sclk      : SPI clock, idle low
// - dac_mosi      : serial data, MSB first
// - dac_ldac_n    : latch strobe, active low
// - busy          : high in every state except IDLE
// All outputs are registered.
module dac_spi_serializer
  import dac_spi_serializer_pkg::*;
#(
  parameter int         DATA_BITS   = 12,
  parameter logic [3:0] CFG         = DAC_CFG_DEFAULT,
  parameter int         SCLK_HALF   = 2,
  parameter int         LDAC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 dac_cs_n,
  output logic                 dac_sclk,
  output logic                 dac_mosi,
  output logic                 dac_ldac_n,
  output logic                 busy
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS);
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int LW         = $clog2(LDAC_CYCLES) + 1;
  // The LDAC pulse also covers the IDLE accept cycle that follows, so the
  // LDAC state itself lasts LDAC_CYCLES-1 cycles (skipped when that is 0).
  localparam int LDAC_LOAD  = (LDAC_CYCLES > 1) ? LDAC_CYCLES - 2 : 0;

  dac_state_e            state, state_d;
  logic [FRAME_BITS-1:0] shreg, shreg_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [LW-1:0]         ldac_cnt, ldac_cnt_d;
  logic                  cs_n_d, sclk_d, mosi_d, ldac_n_d;
  logic                  tick, run;

  assign run = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  spi_tick_gen #(.SCLK_HALF(SCLK_HALF)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // State register plus registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      ldac_cnt     <= '0;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_sclk     <= 1'b0;
      dac_mosi     <= 1'b0;
      dac_ldac_n   <= 1'b1;
    end else begin
      state        <= state_d;
      shreg        <= shreg_d;
      bit_cnt      <= bit_cnt_d;
      ldac_cnt     <= ldac_cnt_d;
      sample_ready <= (state_d == IDLE);
      busy         <= (state_d != IDLE);
      dac_cs_n     <= cs_n_d;
      dac_sclk     <= sclk_d;
      dac_mosi     <= mosi_d;
      dac_ldac_n   <= ldac_n_d;
    end
  end

  // Next state. In SHIFT the registered sclk tells which half-period ends.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (sample_valid && sample_ready) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && !dac_sclk && bit_cnt == '0) state_d = HOLD;
      HOLD:    if (tick) state_d = (LDAC_CYCLES > 1) ? LDAC : IDLE;
      LDAC:    if (ldac_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    ldac_cnt_d = ldac_cnt;
    cs_n_d     = dac_cs_n;
    sclk_d     = dac_sclk;
    mosi_d     = dac_mosi;
    ldac_n_d   = dac_ldac_n;
    unique case (state)
      IDLE: begin
        ldac_n_d = 1'b1;
        if (state_d == SETUP) begin
          shreg_d = {CFG, sample_in};
          mosi_d  = CFG[DAC_CFG_BITS-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      SETUP: if (tick) begin
        sclk_d    = 1'b1;
        bit_cnt_d = BW'(FRAME_BITS - 1);
      end
      SHIFT: if (tick) begin
        if (dac_sclk) begin
          // Falling edge: present the next bit. Zero-fill makes mosi drop
          // to 0 after the last bit with no special case.
          sclk_d  = 1'b0;
          shreg_d = {shreg[FRAME_BITS-2:0], 1'b0};
          mosi_d  = shreg[FRAME_BITS-2];
        end else if (bit_cnt != '0) begin
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt - 1'b1;
        end
      end
      HOLD: if (tick) begin
        cs_n_d     = 1'b1;
        ldac_n_d   = 1'b0;
        ldac_cnt_d = LW'(LDAC_LOAD);
      end
      LDAC: if (ldac_cnt != '0) ldac_cnt_d = ldac_cnt - 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Scoreboard bench for dac_spi_serializer: a default instance (SCLK_HALF=2,
// LDAC_CYCLES=2) and a corner instance (SCLK_HALF=1, LDAC_CYCLES=1).
module tb_dac_spi_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  valid, ready, busy, cs_n, sclk, mosi, ldac_n;
  logic [11:0] samp0, samp1;
  int          checks = 0, failures = 0, cyc = 0;
  logic [15:0] q0[$], q1[$];
  int          ldac_pulses[2];

  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_serializer #(.DATA_BITS(12), .CFG(4'b0011), .SCLK_HALF(2), .LDAC_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .sample_in(samp0), .sample_valid(valid[0]),
    .sample_ready(ready[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
    .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0]), .busy(busy[0]));

  dac_spi_serializer #(.DATA_BITS(12), .CFG(4'b0011), .SCLK_HALF(1), .LDAC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .sample_in(samp1), .sample_valid(valid[1]),
    .sample_ready(ready[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
    .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1]), .busy(busy[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: reassembles frames from MOSI on SCLK rising edges and checks
  // them against the scoreboard when CS_n rises; also checks timing.
  logic [1:0]  p_cs = 2'b11, p_sclk = 2'b00, p_mosi = 2'b00, p_ldac = 2'b11;
  logic [15:0] sh[2];
  int          edges[2], cs_cnt[2], ld_cnt[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0; edges[i] = 0; cs_cnt[i] = 0; ld_cnt[i] = 0; ldac_pulses[i] = 0;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    int          have, hh, ll;
    for (int g = 0; g < 2; g++) begin
      hh = (g == 0) ? 2 : 1;
      ll = (g == 0) ? 2 : 1;
      if (rst) begin
        sh[g] = '0; edges[g] = 0; cs_cnt[g] = 0; ld_cnt[g] = 0;
      end else begin
        if (!cs_n[g])   cs_cnt[g]++;
        if (!ldac_n[g]) ld_cnt[g]++;
        if (!cs_n[g] && sclk[g] && !p_sclk[g]) begin
          check($sformatf("mosi_stable%0d", g), 32'(mosi[g]), 32'(p_mosi[g]));
          sh[g] = {sh[g][14:0], mosi[g]};
          edges[g]++;
        end
        if (cs_n[g] && !p_cs[g]) begin
          have = (g == 0) ? q0.size() : q1.size();
          if (have == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame%0d actual=0x%0h required=none", g, sh[g]);
          end else begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("frame%0d", g), 32'(sh[g]), 32'(e));
          end
          check($sformatf("sclk_edges%0d", g), 32'(edges[g]), 32'd16);
          check($sformatf("cs_low_cycles%0d", g), 32'(cs_cnt[g]), 32'(34 * hh));
          check($sformatf("ldac_follows_cs%0d", g), 32'(ldac_n[g]), 32'd0);
          sh[g] = '0; edges[g] = 0; cs_cnt[g] = 0;
        end
        if (ldac_n[g] && !p_ldac[g]) begin
          check($sformatf("ldac_width%0d", g), 32'(ld_cnt[g]), 32'(ll));
          ld_cnt[g] = 0;
          ldac_pulses[g]++;
        end
      end
    end
    p_cs = cs_n; p_sclk = sclk; p_mosi = mosi; p_ldac = ldac_n;
  end

  // Waits for the accepting posedge of instance g; returns its cycle number.
  task automatic wait_accept(input int g, output int at);
    int n;
    n  = 0;
    at = -1;
    while (!(ready[g] && valid[g]) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL accept_timeout%0d actual=no_ready required=ready_within_300", g);
      return;
    end
    @(posedge clk); #1;
    at = cyc;
  endtask

  task automatic send(input int g, input logic [11:0] s, input logic [15:0] exp,
                      output int at);
    if (g == 0) begin samp0 = s; q0.push_back(exp); end
    else        begin samp1 = s; q1.push_back(exp); end
    valid[g] = 1'b1;
    wait_accept(g, at);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, rises, n, n0;
    logic ps;
    rst = 1'b0; valid = '0; samp0 = '0; samp1 = '0;

    // Reset asserted between clock edges.
    #2 rst = 1'b1;
    #1;
    check("rst_cs_n",   32'(cs_n[0]),   32'd1);
    check("rst_sclk",   32'(sclk[0]),   32'd0);
    check("rst_mosi",   32'(mosi[0]),   32'd0);
    check("rst_ldac_n", 32'(ldac_n[0]), 32'd1);
    check("rst_ready",  32'(ready[0]),  32'd0);
    check("rst_busy",   32'(busy[0]),   32'd0);
    check("rst_busy1",  32'(busy[1]),   32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("ready_before_edge", 32'(ready[0]), 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", 32'(ready[0]), 32'd1);

    // Single frame, valid for one cycle.
    send(0, 12'h7FF, 16'h37FF, t1);
    valid[0] = 1'b0;
    check("ready_low_on_accept", 32'(ready[0]), 32'd0);
    check("busy_on_accept",      32'(busy[0]),  32'd1);
    idle_cycles(75);

    // Back-to-back with valid held high.
    send(0, 12'h000, 16'h3000, t1);
    samp0 = 12'hFFF;
    q0.push_back(16'h3FFF);
    wait_accept(0, t2);
    valid[0] = 1'b0;
    check("b2b_period", 32'(t2 - t1), 32'd70);
    idle_cycles(75);

    // Input changes while busy are ignored until the next IDLE edge.
    send(0, 12'hA5A, 16'h3A5A, t1);
    valid[0] = 1'b0;
    idle_cycles(10);
    samp0 = 12'h123; valid[0] = 1'b1;
    q0.push_back(16'h3123);
    wait_accept(0, t2);
    valid[0] = 1'b0;
    check("busy_ignore_accept_at", 32'(t2 - t1), 32'd70);
    idle_cycles(75);

    // Reset mid-SHIFT after 8 rising edges: no LDAC pulse, next frame clean.
    n0 = ldac_pulses[0];
    samp0 = 12'h555; valid[0] = 1'b1;
    wait_accept(0, t1);
    valid[0] = 1'b0;
    rises = 0; n = 0; ps = sclk[0];
    while (rises < 8 && n < 200) begin
      @(posedge clk); #1; n++;
      if (sclk[0] && !ps) rises++;
      ps = sclk[0];
    end
    check("rises_before_abort", 32'(rises), 32'd8);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n[0]), 32'd1);
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    @(negedge clk); @(negedge clk) rst = 1'b0;
    idle_cycles(80);
    check("abort_no_ldac", 32'(ldac_pulses[0] - n0), 32'd0);
    send(0, 12'h800, 16'h3800, t1);
    valid[0] = 1'b0;
    idle_cycles(75);

    // Corner instance: SCLK = clk/2, one-cycle LDAC, 35-cycle period.
    send(1, 12'h5C3, 16'h35C3, t1);
    samp1 = 12'h0F0;
    q1.push_back(16'h30F0);
    wait_accept(1, t2);
    valid[1] = 1'b0;
    check("corner_period", 32'(t2 - t1), 32'd35);
    idle_cycles(40);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
